// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MA memory arbiter.
// Owner encodings, latency bound, counter width and the data/address sizes live here.
package mem_arb_pkg;

   localparam int SIZE_ADDR      = 16;
   localparam int SIZE_DATA      = 16;
   localparam int MEMARB_MAX_LAT = 4;
   localparam int MEMARB_CNT_W   = 16;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_MA = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

   function automatic logic [MEMARB_CNT_W-1:0] sat_inc(input logic [MEMARB_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_tagpipe.sv
// In-flight read tag shift register: one {valid, owner} entry pushed per cycle,
// the tail entry marks the cycle in which memory read data is valid.
module mem_arb_tagpipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic iw_clk,
   input  logic iw_rst,
   input  logic iw_push_valid,
   input  logic iw_push_owner,
   output logic ow_tail_valid,
   output logic ow_tail_owner
);

   tag_t [DEPTH-1:0] pipe_q;
   tag_t [DEPTH-1:0] pipe_d;
   tag_t             push_tag;

   always_comb begin
      push_tag.valid = iw_push_valid;
      // Non-read slots carry a fixed owner so the pipe never holds stale owner bits.
      push_tag.owner = iw_push_valid ? iw_push_owner : OWN_IF;
      pipe_d         = {pipe_q[DEPTH-2:0], push_tag};
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign ow_tail_valid = pipe_q[DEPTH-1].valid;
   assign ow_tail_owner = pipe_q[DEPTH-1].owner;

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one synchronous single-port RAM between IF and MA.
// Optional MEMARB_STATS_EN adds saturating conflict and hold cycle counters.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1   // legal range 1..MEMARB_MAX_LAT
)(
   input  logic                    iw_clk,
   input  logic                    iw_rst,
   input  logic                    iw_hold,
   input  logic                    iw_if_req,
   input  logic [SIZE_ADDR-1:0]    iw_if_addr,
   output logic                    ow_if_gnt,
   output logic                    ow_if_rvalid,
   output logic [SIZE_DATA-1:0]    ow_if_rdata,
   input  logic                    iw_ma_req,
   input  logic                    iw_ma_we,
   input  logic [SIZE_ADDR-1:0]    iw_ma_addr,
   input  logic [SIZE_DATA-1:0]    iw_ma_wdata,
   output logic                    ow_ma_gnt,
   output logic                    ow_ma_rvalid,
   output logic [SIZE_DATA-1:0]    ow_ma_rdata,
   output logic                    ow_mem_en,
   output logic                    ow_mem_we,
   output logic [SIZE_ADDR-1:0]    ow_mem_addr,
   output logic [SIZE_DATA-1:0]    ow_mem_wdata,
`ifdef MEMARB_STATS_EN
   output logic [MEMARB_CNT_W-1:0] ow_conflict_cnt,
   output logic [MEMARB_CNT_W-1:0] ow_hold_cnt,
`endif
   input  logic [SIZE_DATA-1:0]    iw_mem_rdata
);

   logic                 if_gnt;
   logic                 ma_gnt;
   logic                 last_ma_q,   last_ma_d;
   logic                 mem_en_q,    mem_en_d;
   logic                 mem_we_q,    mem_we_d;
   logic [SIZE_ADDR-1:0] mem_addr_q,  mem_addr_d;
   logic [SIZE_DATA-1:0] mem_wdata_q, mem_wdata_d;
   logic                 if_rvalid_q, if_rvalid_d;
   logic [SIZE_DATA-1:0] if_rdata_q,  if_rdata_d;
   logic                 ma_rvalid_q, ma_rvalid_d;
   logic [SIZE_DATA-1:0] ma_rdata_q,  ma_rdata_d;
   logic                 push_valid;
   logic                 push_owner;
   logic                 tail_valid;
   logic                 tail_owner;

   // Grant: hold (and reset) blocks everything; on conflict the side not served last wins.
   always_comb begin
      if_gnt = 1'b0;
      ma_gnt = 1'b0;
      if (!iw_rst && !iw_hold) begin
         if (iw_if_req && iw_ma_req) begin
            if (last_ma_q) begin
               if_gnt = 1'b1;
            end else begin
               ma_gnt = 1'b1;
            end
         end else begin
            if_gnt = iw_if_req;
            ma_gnt = iw_ma_req;
         end
      end
   end

   always_comb begin
      last_ma_d   = last_ma_q;
      mem_en_d    = if_gnt | ma_gnt;
      mem_we_d    = ma_gnt & iw_ma_we;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (if_gnt) begin
         last_ma_d  = 1'b0;
         mem_addr_d = iw_if_addr;
      end
      if (ma_gnt) begin
         last_ma_d   = 1'b1;
         mem_addr_d  = iw_ma_addr;
         mem_wdata_d = iw_ma_wdata;
      end
   end

   assign push_valid = if_gnt | (ma_gnt & ~iw_ma_we);
   assign push_owner = ma_gnt ? OWN_MA : OWN_IF;

   // One stage per cycle from grant to the cycle the RAM data is valid.
   mem_arb_tagpipe #(
      .DEPTH (MEM_LAT + 1)
   ) u_tagpipe (
      .iw_clk        (iw_clk),
      .iw_rst        (iw_rst),
      .iw_push_valid (push_valid),
      .iw_push_owner (push_owner),
      .ow_tail_valid (tail_valid),
      .ow_tail_owner (tail_owner)
   );

   always_comb begin
      if_rvalid_d = tail_valid && (tail_owner == OWN_IF);
      ma_rvalid_d = tail_valid && (tail_owner == OWN_MA);
      if_rdata_d  = if_rvalid_d ? iw_mem_rdata : if_rdata_q;
      ma_rdata_d  = ma_rvalid_d ? iw_mem_rdata : ma_rdata_q;
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         last_ma_q   <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ma_rvalid_q <= 1'b0;
         ma_rdata_q  <= '0;
      end else begin
         last_ma_q   <= last_ma_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ma_rvalid_q <= ma_rvalid_d;
         ma_rdata_q  <= ma_rdata_d;
      end
   end

   assign ow_if_gnt    = if_gnt;
   assign ow_ma_gnt    = ma_gnt;
   assign ow_if_rvalid = if_rvalid_q;
   assign ow_if_rdata  = if_rdata_q;
   assign ow_ma_rvalid = ma_rvalid_q;
   assign ow_ma_rdata  = ma_rdata_q;
   assign ow_mem_en    = mem_en_q;
   assign ow_mem_we    = mem_we_q;
   assign ow_mem_addr  = mem_addr_q;
   assign ow_mem_wdata = mem_wdata_q;

`ifdef MEMARB_STATS_EN
   logic [MEMARB_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
   logic [MEMARB_CNT_W-1:0] hold_cnt_q,     hold_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      hold_cnt_d     = hold_cnt_q;
      if (iw_if_req && iw_ma_req && !iw_hold) begin
         conflict_cnt_d = sat_inc(conflict_cnt_q);
      end
      if (iw_hold && (iw_if_req || iw_ma_req)) begin
         hold_cnt_d = sat_inc(hold_cnt_q);
      end
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         conflict_cnt_q <= '0;
         hold_cnt_q     <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         hold_cnt_q     <= hold_cnt_d;
      end
   end

   assign ow_conflict_cnt = conflict_cnt_q;
   assign ow_hold_cnt     = hold_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: grant table, directed latency/ordering/reset sequences,
// randomized traffic against a transaction-level model, and a MEM_LAT=4 stream.
`timescale 1ns/1ps
module tb_mem_arb;
   import mem_arb_pkg::*;

   localparam int LAT  = 1;
   localparam int LAT4 = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT (MEM_LAT=1) ----------------
   logic                 hold, if_req, ma_req, ma_we;
   logic [SIZE_ADDR-1:0] if_addr, ma_addr;
   logic [SIZE_DATA-1:0] ma_wdata;
   logic                 if_gnt, ma_gnt, if_rvalid, ma_rvalid;
   logic [SIZE_DATA-1:0] if_rdata, ma_rdata;
   logic                 mem_en, mem_we;
   logic [SIZE_ADDR-1:0] mem_addr;
   logic [SIZE_DATA-1:0] mem_wdata, mem_rdata;
`ifdef MEMARB_STATS_EN
   logic [MEMARB_CNT_W-1:0] conflict_cnt, hold_cnt, conflict_cnt4, hold_cnt4;
`endif

   mem_arb #(.MEM_LAT(LAT)) dut (
      .iw_clk(clk), .iw_rst(rst), .iw_hold(hold),
      .iw_if_req(if_req), .iw_if_addr(if_addr), .ow_if_gnt(if_gnt),
      .ow_if_rvalid(if_rvalid), .ow_if_rdata(if_rdata),
      .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
      .ow_ma_gnt(ma_gnt), .ow_ma_rvalid(ma_rvalid), .ow_ma_rdata(ma_rdata),
      .ow_mem_en(mem_en), .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
`ifdef MEMARB_STATS_EN
      .ow_conflict_cnt(conflict_cnt), .ow_hold_cnt(hold_cnt),
`endif
      .iw_mem_rdata(mem_rdata)
   );

   // RAM model: read data valid MEM_LAT cycles after the command cycle.
   logic [SIZE_DATA-1:0] ram [256];
   logic [SIZE_DATA-1:0] ref_mem [256];
   logic [SIZE_DATA-1:0] rdp [4];
   assign mem_rdata = rdp[LAT-1];
   always @(posedge clk) begin
      for (int i = 3; i > 0; i--) rdp[i] <= rdp[i-1];
      rdp[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : 16'hDEAD;
      if (mem_en && mem_we) ram[mem_addr[7:0]] = mem_wdata;
   end

   // ---------------- DUT (MEM_LAT=4), IF-only stream ----------------
   logic                 if_req4;
   logic [SIZE_ADDR-1:0] if_addr4;
   logic                 if_gnt4, ma_gnt4, if_rvalid4, ma_rvalid4, mem_en4, mem_we4;
   logic [SIZE_DATA-1:0] if_rdata4, ma_rdata4, mem_wdata4, mem_rdata4;
   logic [SIZE_ADDR-1:0] mem_addr4;
   logic [SIZE_DATA-1:0] rdp4 [4];

   mem_arb #(.MEM_LAT(LAT4)) dut4 (
      .iw_clk(clk), .iw_rst(rst), .iw_hold(1'b0),
      .iw_if_req(if_req4), .iw_if_addr(if_addr4), .ow_if_gnt(if_gnt4),
      .ow_if_rvalid(if_rvalid4), .ow_if_rdata(if_rdata4),
      .iw_ma_req(1'b0), .iw_ma_we(1'b0), .iw_ma_addr(16'h0000), .iw_ma_wdata(16'h0000),
      .ow_ma_gnt(ma_gnt4), .ow_ma_rvalid(ma_rvalid4), .ow_ma_rdata(ma_rdata4),
      .ow_mem_en(mem_en4), .ow_mem_we(mem_we4), .ow_mem_addr(mem_addr4), .ow_mem_wdata(mem_wdata4),
`ifdef MEMARB_STATS_EN
      .ow_conflict_cnt(conflict_cnt4), .ow_hold_cnt(hold_cnt4),
`endif
      .iw_mem_rdata(mem_rdata4)
   );

   assign mem_rdata4 = rdp4[LAT4-1];
   always @(posedge clk) begin
      for (int i = 3; i > 0; i--) rdp4[i] <= rdp4[i-1];
      rdp4[0] <= (mem_en4 && !mem_we4) ? (mem_addr4 ^ 16'h5A5A) : 16'hDEAD;
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int                   due;
      logic [SIZE_DATA-1:0] data;
   } rsp_t;
   rsp_t if_exp_q[$];
   rsp_t ma_exp_q[$];

   // Transaction-level model state
   logic                 m_last_ma;
   logic                 c_en, c_we;
   logic [SIZE_ADDR-1:0] c_addr;
   logic [SIZE_DATA-1:0] c_wdata;
   logic                 if_pend, ma_pend;
   int                   cyc;

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      hold = 0; if_req = 0; ma_req = 0; ma_we = 0;
      if_addr = '0; ma_addr = '0; ma_wdata = '0;
      if_req4 = 0; if_addr4 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_if_gnt"},    if_gnt,    0);
      chk({nm, "_ma_gnt"},    ma_gnt,    0);
      chk({nm, "_mem_en"},    mem_en,    0);
      chk({nm, "_mem_we"},    mem_we,    0);
      chk({nm, "_mem_addr"},  mem_addr,  0);
      chk({nm, "_mem_wdata"}, mem_wdata, 0);
      chk({nm, "_if_rvalid"}, if_rvalid, 0);
      chk({nm, "_if_rdata"},  if_rdata,  0);
      chk({nm, "_ma_rvalid"}, ma_rvalid, 0);
      chk({nm, "_ma_rdata"},  ma_rdata,  0);
   endtask

   task automatic rand_cycle(input bit gen);
      logic e_if, e_ma, exp_rv;
      @(posedge clk); #1;
      hold = 1'b0;
      if (gen) begin
         if (!if_pend && $urandom_range(0, 99) < 55) begin
            if_pend = 1'b1;
            if_addr = 16'($urandom_range(0, 15));
         end
         if (!ma_pend && $urandom_range(0, 99) < 55) begin
            ma_pend  = 1'b1;
            ma_we    = ($urandom_range(0, 2) == 0);
            ma_addr  = 16'($urandom_range(0, 15));
            ma_wdata = 16'($urandom);
         end
         hold = ($urandom_range(0, 99) < 8);
      end
      if_req = if_pend;
      ma_req = ma_pend;
      @(negedge clk);
      cyc++;
      e_if = 1'b0;
      e_ma = 1'b0;
      if (!hold) begin
         if (if_req && ma_req) begin
            if (m_last_ma) e_if = 1'b1;
            else           e_ma = 1'b1;
         end else begin
            e_if = if_req;
            e_ma = ma_req;
         end
      end
      chk("rnd_if_gnt", if_gnt, e_if);
      chk("rnd_ma_gnt", ma_gnt, e_ma);
      chk("rnd_mem_en", mem_en, c_en);
      chk("rnd_mem_we", mem_we, c_en && c_we);
      if (c_en) chk("rnd_mem_addr", mem_addr, c_addr);
      if (c_en && c_we) chk("rnd_mem_wdata", mem_wdata, c_wdata);

      exp_rv = (if_exp_q.size() > 0) && (if_exp_q[0].due == cyc);
      chk("rnd_if_rvalid", if_rvalid, exp_rv);
      if (exp_rv) begin
         chk("rnd_if_rdata", if_rdata, if_exp_q[0].data);
         void'(if_exp_q.pop_front());
      end
      exp_rv = (ma_exp_q.size() > 0) && (ma_exp_q[0].due == cyc);
      chk("rnd_ma_rvalid", ma_rvalid, exp_rv);
      if (exp_rv) begin
         chk("rnd_ma_rdata", ma_rdata, ma_exp_q[0].data);
         void'(ma_exp_q.pop_front());
      end

      c_en = e_if | e_ma;
      c_we = e_ma && ma_we;
      if (e_if) c_addr = if_addr;
      if (e_ma) c_addr = ma_addr;
      if (e_ma && ma_we) c_wdata = ma_wdata;
      if (e_if) begin
         m_last_ma = 1'b0;
         if_exp_q.push_back('{cyc + 2 + LAT, ref_mem[if_addr[7:0]]});
      end
      if (e_ma) begin
         m_last_ma = 1'b1;
         if (ma_we) ref_mem[ma_addr[7:0]] = ma_wdata;
         else       ma_exp_q.push_back('{cyc + 2 + LAT, ref_mem[ma_addr[7:0]]});
      end
      if (if_gnt) if_pend = 1'b0;
      if (ma_gnt) ma_pend = 1'b0;
   endtask

   // ---------------- grant table ----------------
   typedef struct {
      logic hold, if_req, ma_req, e_if, e_ma;
   } vec_t;
   vec_t vecs [13];

   // ---------------- main test ----------------
   initial begin
      logic prev_en;
      for (int i = 0; i < 256; i++) ram[i] = '0;
      for (int i = 0; i < 4; i++) begin rdp[i] = '0; rdp4[i] = '0; end

      // Reset state
      do_reset();
      chk_zero("reset");

      // Grant table from reset (IF wins the first conflict)
      vecs[0]  = '{1, 1, 1, 0, 0};
      vecs[1]  = '{0, 1, 0, 1, 0};
      vecs[2]  = '{0, 1, 1, 0, 1};
      vecs[3]  = '{0, 1, 1, 1, 0};
      vecs[4]  = '{1, 1, 1, 0, 0};
      vecs[5]  = '{1, 1, 1, 0, 0};
      vecs[6]  = '{1, 1, 1, 0, 0};
      vecs[7]  = '{0, 1, 1, 0, 1};
      vecs[8]  = '{0, 0, 1, 0, 1};
      vecs[9]  = '{0, 1, 1, 1, 0};
      vecs[10] = '{0, 0, 0, 0, 0};
      vecs[11] = '{1, 1, 0, 0, 0};
      vecs[12] = '{0, 1, 1, 0, 1};
      prev_en = 1'b0;
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         hold = vecs[i].hold; if_req = vecs[i].if_req; ma_req = vecs[i].ma_req;
         ma_we = 1'b0; if_addr = 16'(i); ma_addr = 16'(i + 64);
         @(negedge clk);
         chk($sformatf("tbl%0d_if_gnt", i), if_gnt, vecs[i].e_if);
         chk($sformatf("tbl%0d_ma_gnt", i), ma_gnt, vecs[i].e_ma);
         chk($sformatf("tbl%0d_mem_en", i), mem_en, prev_en);
         prev_en = vecs[i].e_if | vecs[i].e_ma;
      end
      @(posedge clk); #1;
      hold = 0; if_req = 0; ma_req = 0;
      @(negedge clk);
`ifdef MEMARB_STATS_EN
      chk("tbl_hold_cnt",     hold_cnt,     5);
      chk("tbl_conflict_cnt", conflict_cnt, 5);
`endif

      // IF read of 0x10, MEM_LAT=1: gnt at T, command at T+1, rvalid at T+3
      do_reset();
      ram[8'h10] = 16'hAAAA;
      @(posedge clk); #1; if_req = 1; if_addr = 16'h0010;
      @(negedge clk); chk("a_if_gnt", if_gnt, 1);
      @(posedge clk); #1; if_req = 0;
      @(negedge clk);
      chk("a_mem_en", mem_en, 1);
      chk("a_mem_addr", mem_addr, 16'h0010);
      chk("a_mem_we", mem_we, 0);
      chk("a_rvalid_t1", if_rvalid, 0);
      @(negedge clk); chk("a_rvalid_t2", if_rvalid, 0);
      @(negedge clk);
      chk("a_rvalid_t3", if_rvalid, 1);
      chk("a_rdata_t3", if_rdata, 16'hAAAA);
      chk("a_ma_rvalid_t3", ma_rvalid, 0);
      @(negedge clk);
      chk("a_rvalid_t4", if_rvalid, 0);
      chk("a_rdata_held", if_rdata, 16'hAAAA);

      // MA write 0x1234 to 0x20 then read back
      @(posedge clk); #1; ma_req = 1; ma_we = 1; ma_addr = 16'h0020; ma_wdata = 16'h1234;
      @(negedge clk); chk("b_wr_gnt", ma_gnt, 1);
      @(posedge clk); #1; ma_we = 0;
      @(negedge clk);
      chk("b_rd_gnt", ma_gnt, 1);
      chk("b_wr_mem_we", mem_we, 1);
      chk("b_wr_mem_wdata", mem_wdata, 16'h1234);
      @(posedge clk); #1; ma_req = 0;
      @(negedge clk);
      chk("b_rd_mem_we", mem_we, 0);
      chk("b_rd_mem_en", mem_en, 1);
      chk("b_rvalid_t1", ma_rvalid, 0);
      @(negedge clk); chk("b_no_wr_rvalid", ma_rvalid, 0);
      @(negedge clk);
      chk("b_rvalid_t3", ma_rvalid, 1);
      chk("b_rdata", ma_rdata, 16'h1234);
      chk("b_no_if_rvalid", if_rvalid, 0);

      // Reset one cycle after an IF read grant drops the read
      @(posedge clk); #1; if_req = 1; if_addr = 16'h0030;
      @(negedge clk); chk("c_if_gnt", if_gnt, 1);
      @(posedge clk); #1; if_req = 0; rst = 1;
      #1; chk_zero("c_rst");
      @(negedge clk); rst = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); chk("c_no_rvalid", if_rvalid, 0);
      end

      // Randomized traffic against the transaction model
      do_reset();
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 16'($urandom);
         ref_mem[i] = ram[i];
      end
      m_last_ma = 1'b1; c_en = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      if_pend = 0; ma_pend = 0; cyc = 0;
      if_exp_q.delete(); ma_exp_q.delete();
      for (int i = 0; i < 400; i++) rand_cycle(1'b1);
      for (int i = 0; i < 20; i++) begin
         if (if_pend || ma_pend || if_exp_q.size() > 0 || ma_exp_q.size() > 0) rand_cycle(1'b0);
      end
      chk("rnd_drain_if", if_exp_q.size(), 0);
      chk("rnd_drain_ma", ma_exp_q.size(), 0);

      // MEM_LAT=4 IF stream: 8 back-to-back reads, rvalid 6 cycles after each grant
      do_reset();
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         if_req4  = (c < 8);
         if_addr4 = 16'(c);
         @(negedge clk);
         if (c < 8) chk($sformatf("l4_gnt%0d", c), if_gnt4, 1);
         chk($sformatf("l4_rvalid%0d", c), if_rvalid4, (c >= 6 && c < 14));
         if (c >= 6 && c < 14) chk($sformatf("l4_rdata%0d", c), if_rdata4, 16'(c - 6) ^ 16'h5A5A);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
      $fatal(1);
   end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter sharing one single-port synchronous memory between two requesters: the instruction-fetch stage (IF, read-only) and the memory-access stage (MA, read/write).
- Sits between the pipeline stages and the RAM. Grants at most one request per cycle, round-robin on conflict, and drives the registered memory command.
- Routes each read response back to its owner via an in-flight tag pipeline.

Parameters:
- MEM_LAT, 1, cycles from command presented on ow_mem_* to valid iw_mem_rdata; legal range 1..4.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, asynchronous, active-high
- iw_hold  in  1  suppress all grants this cycle (halt/debug)
- iw_if_req  in  1  IF read request
- iw_if_addr  in  `SIZE_ADDR  IF address
- ow_if_gnt  out  1  IF request accepted this cycle
- ow_if_rvalid  out  1  IF read data valid (1-cycle pulse)
- ow_if_rdata  out  `SIZE_DATA  IF read data, held until next IF rvalid
- iw_ma_req  in  1  MA request
- iw_ma_we  in  1  MA write (1) / read (0)
- iw_ma_addr  in  `SIZE_ADDR  MA address
- iw_ma_wdata  in  `SIZE_DATA  MA write data
- ow_ma_gnt  out  1  MA request accepted
- ow_ma_rvalid  out  1  MA read data valid
- ow_ma_rdata  out  `SIZE_DATA  MA read data, held
- ow_mem_en  out  1  memory command valid
- ow_mem_we  out  1  memory write
- ow_mem_addr  out  `SIZE_ADDR  memory address
- ow_mem_wdata  out  `SIZE_DATA  memory write data
- iw_mem_rdata  in  `SIZE_DATA  memory read data

Behaviour:
- Reset values:
  - All outputs 0.
  - r_last_ma=1, so IF wins the first conflict.
  - Tag pipeline cleared.
- Grant (combinational, cycle T):
  - iw_hold=1: both gnt=0.
  - Only one req high: that requester is granted.
  - Both high: MA granted if r_last_ma=0, else IF.
  - r_last_ma updates on every grant (1 if MA granted, 0 if IF granted). Unchanged when no grant.
- Requester handshake:
  - A requester holds req/addr/we/wdata stable until gnt.
  - gnt=0 means stall; req may deassert only after gnt.
- Command (T+1): ow_mem_en=1, with ow_mem_we/addr/wdata registered from the granted requester. Without a grant, ow_mem_en=0, ow_mem_we=0, and addr/wdata hold their last values.
- Tag pipeline:
  - Depth MEM_LAT+1; each entry holds {valid, owner}.
  - A read grant pushes {1, owner}; a write or no grant pushes {0, x}.
- Response:
  - At T+1+MEM_LAT, iw_mem_rdata is sampled when the tag at the pipeline tail is valid.
  - At T+2+MEM_LAT, the owner's rvalid=1 for one cycle and rdata is updated. MEM_LAT=1 gives rvalid at T+3.
  - Writes never produce rvalid.
- Ordering:
  - Commands reach memory in grant order; responses return in that order.
  - An MA write followed by a read of the same address returns the written data (memory semantics; the arbiter adds no reordering).
- Throughput: one grant per cycle; back-to-back grants to the same requester are allowed when the other is idle.
- Simultaneous events:
  - hold plus both requests: no grant, r_last_ma unchanged.
  - Responses for IF and MA can never land in the same cycle.
- Reset mid-operation: tags cleared, in-flight reads dropped, no rvalid after reset deasserts until a new grant.

Optional Feature:
- MEMARB_STATS_EN defined adds two outputs, each 16-bit saturating at 16'hFFFF and reset to 0:
  - ow_conflict_cnt: increments each cycle both reqs are high and hold=0.
  - ow_hold_cnt: increments each cycle hold=1 while any req is high.
- Undefined: ports and counters absent, no logic.

Decomposition:
- Shared header memarb.vh:
  - OWN_IF=1'b0, OWN_MA=1'b1
  - MEMARB_MAX_LAT=4
  - MEMARB_CNT_W=16
- Widths come from sizes.vh.
- One sub-module, mem_arb_tagpipe: parameterised shift register of {valid, owner}, with push input and tail output.

Test Plan:
- Reset, then IF only, addr 0x10, memory returns 0xAAAA → if_gnt at T, mem_en/addr=0x10 at T+1, if_rvalid with rdata=0xAAAA at T+3 (MEM_LAT=1).
- IF and MA both request every cycle, 6 cycles → grants alternate IF, MA, IF, MA, IF, MA; each requester's rvalids arrive in order.
- MA write 0x1234 to addr 0x20, then MA read of 0x20 → mem_we=1 then 0; ma_rvalid only for the read, rdata=0x1234; no IF rvalid.
- hold=1 for 3 cycles with both requesting → no gnt, mem_en=0; after release, the grant follows the pre-hold r_last_ma; with MEMARB_STATS_EN, hold_cnt=3.
- Reset asserted one cycle after an IF read grant → no if_rvalid ever for that read; all outputs 0.
- MEM_LAT=4 sweep, streaming IF reads → rvalid latency 6 cycles, one per cycle, no drops.
